// File: rtl/i_cache_pkg.sv
// Shared widths, geometry defaults and the controller state type for the instruction cache.
// Word-address helper keeps alignment handling in one place.
package i_cache_pkg;

  localparam int ADDR_LEN          = 32;
  localparam int INST_LEN          = 32;
  localparam int ICACHE_INDEX_BITS = 7;
  localparam int ICACHE_TAG_LEN    = ADDR_LEN - ICACHE_INDEX_BITS - 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  // Fetch PCs are always treated as word-aligned; the low two bits are dropped.
  function automatic logic [ADDR_LEN-1:0] word_addr(input logic [ADDR_LEN-1:0] addr);
    return {addr[ADDR_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// Fetch-side (IF) and refill-side (mem_ctrl) signals of the instruction cache.
// The cache uses the slave view; the surrounding pipeline/memory uses the master view.
interface i_cache_if;
  import i_cache_pkg::*;

  logic                if_req;
  logic [ADDR_LEN-1:0] if_addr;
  logic                flush;
  logic [INST_LEN-1:0] inst_o;
  logic                inst_valid_o;
  logic                busy_o;
  logic                icache_needed;
  logic [ADDR_LEN-1:0] icache_addr;
  logic                inst_available_i;
  logic [INST_LEN-1:0] inst_icache_i;

  modport slave (
    input  if_req, if_addr, flush, inst_available_i, inst_icache_i,
    output inst_o, inst_valid_o, busy_o, icache_needed, icache_addr
  );

  modport master (
    output if_req, if_addr, flush, inst_available_i, inst_icache_i,
    input  inst_o, inst_valid_o, busy_o, icache_needed, icache_addr
  );

endinterface

// File: rtl/i_cache_array.sv
// Direct-mapped storage: synchronous-write data/tag arrays with asynchronous read.
// Only the valid bits are reset, so a reset invalidates the whole cache at once.
module icache_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_LEN    = 23,
  parameter int DATA_LEN   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_idx,
  input  logic [TAG_LEN-1:0]    w_tag,
  input  logic [DATA_LEN-1:0]   w_data,
  input  logic [INDEX_BITS-1:0] r_idx,
  output logic [TAG_LEN-1:0]    r_tag,
  output logic [DATA_LEN-1:0]   r_data,
  output logic                  r_valid
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [DATA_LEN-1:0] data_mem [ENTRIES];
  logic [TAG_LEN-1:0]  tag_mem  [ENTRIES];
  logic [ENTRIES-1:0]  valid_r;

  // Valid bits: cleared asynchronously, set by every fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (we) begin
      valid_r[w_idx] <= 1'b1;
    end
  end

  // Data and tag payload, no reset needed since valid guards every read.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[w_idx] <= w_data;
      tag_mem[w_idx]  <= w_tag;
    end
  end

  assign r_data  = data_mem[r_idx];
  assign r_tag   = tag_mem[r_idx];
  assign r_valid = valid_r[r_idx];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, single outstanding refill on a miss.
// A flush during a refill still installs the word but suppresses its delivery to IF.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input logic    clk,
  input logic    rst,
  i_cache_if.slave bus
);

  localparam int TAG_LEN = ADDR_LEN - INDEX_BITS - 2;

  state_e              state_r, state_s;
  logic                discard_r, discard_s;
  logic [INST_LEN-1:0] inst_r, inst_s;
  logic                inst_valid_r, inst_valid_s;
  logic                busy_r, busy_s;
  logic                needed_r, needed_s;
  logic [ADDR_LEN-1:0] addr_r, addr_s;

  logic [INDEX_BITS-1:0] lookup_idx_s;
  logic [TAG_LEN-1:0]    lookup_tag_s;
  logic [TAG_LEN-1:0]    entry_tag_s;
  logic [INST_LEN-1:0]   entry_data_s;
  logic                  entry_valid_s;
  logic                  hit_s;
  logic                  fill_we_s;
  logic                  unused_s;

  assign lookup_idx_s = bus.if_addr[INDEX_BITS+1:2];
  assign lookup_tag_s = bus.if_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign hit_s        = entry_valid_s && (entry_tag_s == lookup_tag_s);
  assign unused_s     = ^bus.if_addr[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_LEN    (TAG_LEN),
    .DATA_LEN   (INST_LEN)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (fill_we_s),
    .w_idx   (addr_r[INDEX_BITS+1:2]),
    .w_tag   (addr_r[ADDR_LEN-1:INDEX_BITS+2]),
    .w_data  (bus.inst_icache_i),
    .r_idx   (lookup_idx_s),
    .r_tag   (entry_tag_s),
    .r_data  (entry_data_s),
    .r_valid (entry_valid_s)
  );

  // Next-state and next-output logic of the lookup/refill controller.
  always_comb begin
    state_s      = state_r;
    discard_s    = discard_r;
    inst_s       = inst_r;
    inst_valid_s = 1'b0;
    busy_s       = busy_r;
    needed_s     = needed_r;
    addr_s       = addr_r;
    fill_we_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.if_req && !bus.flush) begin
          if (hit_s) begin
            inst_s       = entry_data_s;
            inst_valid_s = 1'b1;
          end else begin
            state_s   = ST_MISS;
            busy_s    = 1'b1;
            needed_s  = 1'b1;
            addr_s    = word_addr(bus.if_addr);
            discard_s = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MISS: begin
        // mem_ctrl cannot abort, so a flush only marks the pending word as stale.
        if (bus.flush) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
        if (bus.inst_available_i) begin
          fill_we_s = 1'b1;
          state_s   = ST_IDLE;
          busy_s    = 1'b0;
          needed_s  = 1'b0;
          if (!discard_r && !bus.flush) begin
            inst_s       = bus.inst_icache_i;
            inst_valid_s = 1'b1;
          end else begin
            inst_valid_s = 1'b0;
          end
        end else begin
          state_s = ST_MISS;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        needed_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      discard_r    <= 1'b0;
      inst_r       <= {INST_LEN{1'b0}};
      inst_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      needed_r     <= 1'b0;
      addr_r       <= {ADDR_LEN{1'b0}};
    end else begin
      state_r      <= state_s;
      discard_r    <= discard_s;
      inst_r       <= inst_s;
      inst_valid_r <= inst_valid_s;
      busy_r       <= busy_s;
      needed_r     <= needed_s;
      addr_r       <= addr_s;
    end
  end

  assign bus.inst_o        = inst_r;
  assign bus.inst_valid_o  = inst_valid_r;
  assign bus.busy_o        = busy_r;
  assign bus.icache_needed = needed_r;
  assign bus.icache_addr   = addr_r;

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed miss/hit/conflict/flush/reset sequences
// plus a table of back-to-back hit and flush-priority vectors.
module tb_i_cache;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  i_cache_if ifc ();

  i_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        fl;
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  // Full miss transaction; the stub answers lat cycles after the request edge.
  task automatic miss(input logic [31:0] a, input logic [31:0] d, input int lat,
                      input logic fl, input string nm);
    ifc.if_req  = 1'b1;
    ifc.if_addr = a;
    step();
    check({nm, " needed"}, {31'd0, ifc.icache_needed}, 32'd1);
    check({nm, " busy"},   {31'd0, ifc.busy_o}, 32'd1);
    check({nm, " addr"},   ifc.icache_addr, {a[31:2], 2'b00});
    check({nm, " novalid"}, {31'd0, ifc.inst_valid_o}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      ifc.if_req  = 1'b1;
      ifc.if_addr = a + 32'h0000_0040;
      ifc.flush   = fl && (i == 1);
      step();
    end
    ifc.if_req = 1'b0;
    ifc.flush  = 1'b0;
    check({nm, " addr held"}, ifc.icache_addr, {a[31:2], 2'b00});
    ifc.inst_available_i = 1'b1;
    ifc.inst_icache_i    = d;
    step();
    ifc.inst_available_i = 1'b0;
    check({nm, " valid"}, {31'd0, ifc.inst_valid_o}, {31'd0, ~fl});
    if (!fl) check({nm, " data"}, ifc.inst_o, d);
    check({nm, " busy off"},   {31'd0, ifc.busy_o}, 32'd0);
    check({nm, " needed off"}, {31'd0, ifc.icache_needed}, 32'd0);
    step();
    check({nm, " single pulse"}, {31'd0, ifc.inst_valid_o}, 32'd0);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d, input string nm);
    ifc.if_req  = 1'b1;
    ifc.if_addr = a;
    step();
    ifc.if_req = 1'b0;
    check({nm, " valid"},  {31'd0, ifc.inst_valid_o}, 32'd1);
    check({nm, " data"},   ifc.inst_o, d);
    check({nm, " needed"}, {31'd0, ifc.icache_needed}, 32'd0);
    step();
    check({nm, " single pulse"}, {31'd0, ifc.inst_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    total  = 0;
    passed = 0;
    rst = 1'b0;
    ifc.if_req = 1'b0;
    ifc.if_addr = 32'd0;
    ifc.flush = 1'b0;
    ifc.inst_available_i = 1'b0;
    ifc.inst_icache_i = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_0013, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1004, 1'b1, 32'h1111_1111, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1008, 1'b1, 32'h2222_2222, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_1004, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_100B, 1'b1, 32'h2222_2222, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b1};

    step();
    step();
    check("rst inst_o",     ifc.inst_o, 32'd0);
    check("rst valid",      {31'd0, ifc.inst_valid_o}, 32'd0);
    check("rst busy",       {31'd0, ifc.busy_o}, 32'd0);
    check("rst needed",     {31'd0, ifc.icache_needed}, 32'd0);
    check("rst addr",       ifc.icache_addr, 32'd0);
    rst = 1'b1;
    step();

    miss(32'h0000_1000, 32'h0000_0013, 5, 1'b0, "miss1000");
    hit(32'h0000_1000, 32'h0000_0013, "hit1000");
    miss(32'h0000_1200, 32'hDEAD_BEEF, 3, 1'b0, "conflict1200");
    miss(32'h0000_1000, 32'h0000_0013, 4, 1'b0, "refill1000");
    miss(32'h0000_2000, 32'hCAFE_F00D, 4, 1'b1, "flushmiss2000");
    hit(32'h0000_2000, 32'hCAFE_F00D, "hit2000");
    miss(32'h0000_1002, 32'h0000_0013, 2, 1'b0, "refill1000b");
    miss(32'h0000_1004, 32'h1111_1111, 2, 1'b0, "fill1004");
    miss(32'h0000_1008, 32'h2222_2222, 2, 1'b0, "fill1008");

    // Consecutive-cycle vectors: each result is checked while the next request is driven.
    for (int i = 0; i < 8; i++) begin
      ifc.if_req  = vecs[i].req;
      ifc.flush   = vecs[i].fl;
      ifc.if_addr = vecs[i].addr;
      step();
      check($sformatf("vec%0d valid", i), {31'd0, ifc.inst_valid_o}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("vec%0d data", i), ifc.inst_o, vecs[i].exp_data);
      check($sformatf("vec%0d busy", i), {31'd0, ifc.busy_o}, {31'd0, vecs[i].exp_busy});
    end
    ifc.if_req = 1'b0;
    ifc.flush  = 1'b0;
    check("alias2000 addr", ifc.icache_addr, 32'h0000_2000);
    ifc.inst_available_i = 1'b1;
    ifc.inst_icache_i    = 32'hCAFE_F00D;
    step();
    ifc.inst_available_i = 1'b0;
    check("alias2000 valid", {31'd0, ifc.inst_valid_o}, 32'd1);
    check("alias2000 data",  ifc.inst_o, 32'hCAFE_F00D);
    step();

    // Reset in the middle of a refill.
    ifc.if_req  = 1'b1;
    ifc.if_addr = 32'h0000_3000;
    step();
    ifc.if_req = 1'b0;
    check("midrst needed before", {31'd0, ifc.icache_needed}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst needed async", {31'd0, ifc.icache_needed}, 32'd0);
    check("midrst busy async",   {31'd0, ifc.busy_o}, 32'd0);
    check("midrst addr async",   ifc.icache_addr, 32'd0);
    step();
    step();
    rst = 1'b1;
    ifc.inst_available_i = 1'b1;
    ifc.inst_icache_i    = 32'h5555_5555;
    step();
    ifc.inst_available_i = 1'b0;
    check("late fill valid",  {31'd0, ifc.inst_valid_o}, 32'd0);
    check("late fill busy",   {31'd0, ifc.busy_o}, 32'd0);
    check("late fill needed", {31'd0, ifc.icache_needed}, 32'd0);
    step();
    miss(32'h0000_1004, 32'h1111_1111, 3, 1'b0, "postrst1004");
    miss(32'h0000_3000, 32'h0000_0093, 3, 1'b0, "postrst3000");
    hit(32'h0000_3000, 32'h0000_0093, "hit3000");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
